output_ram_writer: RTL and testbench

OUTPUT_RAM_WRITER -- requirements
Module: output_ram_writer

---
 rtl/output_ram_writer.sv | 128 ++++++++++++
 tb/tb_output_ram_writer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_ram_writer.sv
// Streams one frame of pixels into RAM at consecutive addresses from BASE_ADDR, one write per accepted pixel.
// Latency 1 (accept -> ram_wren). in_ready is high only in WRITE; in_valid=0 stalls without side effects.
module output_ram_writer #(
    parameter int          IMG_WIDTH  = 256,
    parameter int          IMG_HEIGHT = 256,
    parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CNT_W = $clog2(NPIX + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPIX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        ptr_q, ptr_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wren_q, wren_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         data_q, data_d;

    logic accept;
    logic last_pix;

    assign accept   = (state_q == S_WRITE) && in_valid;
    // Column/row and the flat count must agree on the final pixel.
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRITE;
                    ptr_d   = BASE_ADDR;
                    col_d   = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    wren_d = 1'b1;
                    addr_d = ptr_q;
                    data_d = in_data;
                    ptr_d  = ptr_q + 16'd1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_pix) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE_ADDR;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign in_ready    = (state_q == S_WRITE);
    assign busy        = (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign ram_wren    = wren_q;
    assign ram_address = addr_q;
    assign ram_data    = data_q;

endmodule

// File: tb/tb_output_ram_writer.sv
// Bench for output_ram_writer: two instances (base 0x0010 and 0xFFFC) share stimulus; a frame model
// pushes expected writes on accept and a negedge monitor pops and compares them.
module tb_output_ram_writer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        rdy_a, rdy_b, busy_a, busy_b, done_a, done_b, wren_a, wren_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;

    output_ram_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .BASE_ADDR(16'h0010)) dut_a (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .ram_address(addr_a), .ram_data(data_a), .ram_wren(wren_a),
        .busy(busy_a), .done(done_a)
    );

    output_ram_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .BASE_ADDR(16'hFFFC)) dut_b (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .ram_address(addr_b), .ram_data(data_b), .ram_wren(wren_b),
        .busy(busy_b), .done(done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 write, 2 done; m_cnt is the flat pixel index
    int          m_st  = 0;
    int          m_cnt = 0;
    logic [23:0] qa[$];
    logic [23:0] qb[$];

    always @(posedge clock) begin
        if (reset) begin
            m_st  = 0;
            m_cnt = 0;
        end else begin
            case (m_st)
                0: if (start) begin m_st = 1; m_cnt = 0; end
                1: if (in_valid) begin
                       qa.push_back({16'h0010 + 16'(m_cnt), in_data});
                       qb.push_back({16'hFFFC + 16'(m_cnt), in_data});
                       m_cnt = m_cnt + 1;
                       if (m_cnt == 8) m_st = 2;
                   end
                default: m_st = 0;
            endcase
        end
    end

    bit          mon_en = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          run = 0;
    int          max_run = 0;
    int          cyc = 0;
    int          last_done_cyc = -1;
    int          done_gap = 0;
    logic [23:0] exp_w;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (mon_en) begin
            n_vec++;
            if (rdy_a !== (m_st == 1) || rdy_b !== (m_st == 1)) begin
                n_err++;
                $display("FAIL in_ready: got %b/%b want %b", rdy_a, rdy_b, (m_st == 1));
            end
            n_vec++;
            if (busy_a !== (m_st == 1) || done_a !== (m_st == 2)) begin
                n_err++;
                $display("FAIL busy_done: got busy=%b done=%b want busy=%b done=%b",
                         busy_a, done_a, (m_st == 1), (m_st == 2));
            end
            n_vec++;
            if (wren_a !== (qa.size() != 0) || wren_b !== (qb.size() != 0)) begin
                n_err++;
                $display("FAIL ram_wren: got %b/%b want %b", wren_a, wren_b, (qa.size() != 0));
            end
            if (wren_a === 1'b1 && qa.size() != 0) begin
                exp_w = qa.pop_front();
                n_vec++;
                if ({addr_a, data_a} !== exp_w) begin
                    n_err++;
                    $display("FAIL write_a: got addr=%h data=%h want addr=%h data=%h",
                             addr_a, data_a, exp_w[23:8], exp_w[7:0]);
                end
            end
            if (wren_b === 1'b1 && qb.size() != 0) begin
                exp_w = qb.pop_front();
                n_vec++;
                if ({addr_b, data_b} !== exp_w) begin
                    n_err++;
                    $display("FAIL write_b_wrap: got addr=%h data=%h want addr=%h data=%h",
                             addr_b, data_b, exp_w[23:8], exp_w[7:0]);
                end
            end
            if (wren_a === 1'b1) begin
                wr_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (done_a === 1'b1) begin
                done_cnt++;
                if (last_done_cyc >= 0) done_gap = cyc - last_done_cyc;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear_stats();
        wr_cnt = 0;
        done_cnt = 0;
        run = 0;
        max_run = 0;
        last_done_cyc = -1;
        done_gap = 0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (done_cnt < target) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d done pulses want %0d", name, done_cnt, target);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        tick();
        mon_en = 1;
        repeat (2) tick();
        n_vec++;
        if (wren_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0 || rdy_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got wren=%b done=%b busy=%b rdy=%b want 0000",
                     wren_a, done_a, busy_a, rdy_a);
        end
        n_vec++;
        if (addr_a !== 16'h0010 || addr_b !== 16'hFFFC || data_a !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h/%h data=%h want 0010/fffc 00", addr_a, addr_b, data_a);
        end
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_frame();
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_done(1, 10, "single");
        n_vec++;
        if (wr_cnt != 8 || done_cnt != 1 || max_run != 8) begin
            n_err++;
            $display("FAIL single_frame: got writes=%0d dones=%0d run=%0d want 8 1 8", wr_cnt, done_cnt, max_run);
        end
        n_vec++;
        if (rdy_a !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready_after: got %b want 0", rdy_a);
        end
    endtask

    task automatic test_stall();
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 22; i++) begin
            in_valid = (i % 3 == 0);
            in_data  = 8'h30 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_done(1, 10, "stall");
        n_vec++;
        if (wr_cnt != 8 || done_cnt != 1 || max_run != 1) begin
            n_err++;
            $display("FAIL stall: got writes=%0d dones=%0d run=%0d want 8 1 1", wr_cnt, done_cnt, max_run);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
        end
        reset = 1'b1; start = 1'b1; in_data = 8'hEE;
        repeat (2) tick();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (wr_cnt != 3 || done_cnt != 0) begin
            n_err++;
            $display("FAIL reset_abort: got writes=%0d dones=%0d want 3 0", wr_cnt, done_cnt);
        end
        n_vec++;
        if (wren_a !== 1'b0 || addr_a !== 16'h0010 || data_a !== 8'h00 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort_vals: got wren=%b addr=%h data=%h busy=%b want 0 0010 00 0",
                     wren_a, addr_a, data_a, busy_a);
        end
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'h70 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_done(1, 10, "restart");
        n_vec++;
        if (wr_cnt != 8 || done_cnt != 1) begin
            n_err++;
            $display("FAIL restart: got writes=%0d dones=%0d want 8 1", wr_cnt, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        start = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 60 && done_cnt < 2; k++) begin
            in_data = 8'($urandom);
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        wait_done(2, 5, "b2b");
        n_vec++;
        if (wr_cnt != 16 || done_cnt != 2) begin
            n_err++;
            $display("FAIL b2b_counts: got writes=%0d dones=%0d want 16 2", wr_cnt, done_cnt);
        end
        // 8 writes + DONE + one IDLE cycle between the two done pulses
        n_vec++;
        if (done_gap != 10) begin
            n_err++;
            $display("FAIL b2b_gap: got %0d cycles between done pulses want 10", done_gap);
        end
    endtask

    task automatic test_start_during_write();
        clear_stats();
        start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            start    = (i < 12);
            in_valid = (i % 2 == 0);
            in_data  = 8'(i * 7 + 3);
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        wait_done(1, 10, "start_in_write");
        n_vec++;
        if (wr_cnt != 8 || done_cnt != 1) begin
            n_err++;
            $display("FAIL start_in_write: got writes=%0d dones=%0d want 8 1", wr_cnt, done_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_single_frame();
        test_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_start_during_write();
        n_vec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_err++;
            $display("FAIL leftover_writes: got %0d/%0d pending want 0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
